// File: rtl/line_number_parser.sv
// Streaming decimal line parser: scans packed ASCII words one lane per cycle and
// emits one unsigned value per SEPARATOR-terminated (or in_last-flushed) line.
module line_number_parser #(
    parameter int          LANES       = 8,
    parameter int          VALUE_WIDTH = 32,
    parameter logic [7:0]  SEPARATOR   = 8'h0A
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [8*LANES-1:0]     in_data,
    input  logic                   in_last,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [VALUE_WIDTH-1:0] out_value,
    output logic                   out_overflow,
    output logic                   out_error,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [15:0]            line_count
);
    localparam int             CW        = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CW-1:0]  LAST_LANE = CW'(LANES - 1);

    typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_t;

    typedef struct packed {
        logic [VALUE_WIDTH-1:0] value;
        logic                   overflow;
        logic                   error;
    } result_t;

    state_t                 state_q, state_d;
    logic [LANES-1:0][7:0]  buf_q, buf_d;
    logic                   last_q, last_d;
    logic [CW-1:0]          cursor_q, cursor_d;
    logic [VALUE_WIDTH-1:0] acc_q, acc_d;
    logic                   have_q, have_d, ovf_q, ovf_d, err_q, err_d;
    result_t                res_q, res_d;
    logic [15:0]            cnt_q, cnt_d;

    logic [7:0]             b;
    logic                   is_digit, at_last, emit;
    logic [VALUE_WIDTH+3:0] wide;
    logic [VALUE_WIDTH-1:0] n_acc;
    logic                   n_have, n_ovf, n_err;

    assign b        = buf_q[cursor_q];
    assign is_digit = (b >= 8'h30) && (b <= 8'h39);
    assign at_last  = (cursor_q == LAST_LANE);
    // Four guard bits hold acc*10+9 exactly, so any set guard bit is a true overflow.
    assign wide     = {4'b0, acc_q} * (VALUE_WIDTH+4)'(10) + (VALUE_WIDTH+4)'(b[3:0]);

    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        last_d   = last_q;
        cursor_d = cursor_q;
        acc_d    = acc_q;
        have_d   = have_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        n_acc    = acc_q;
        n_have   = have_q;
        n_ovf    = ovf_q;
        n_err    = err_q;
        emit     = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    buf_d    = in_data;
                    last_d   = in_last;
                    cursor_d = '0;
                    state_d  = SCAN;
                end
            end
            SCAN: begin
                if (is_digit) begin
                    n_acc  = wide[VALUE_WIDTH-1:0];
                    n_ovf  = ovf_q | (|wide[VALUE_WIDTH+3:VALUE_WIDTH]);
                    n_have = 1'b1;
                end else if (b == SEPARATOR) begin
                    if (have_q) emit = 1'b1;
                    else        n_err = 1'b0;
                end else if (b != 8'h00 && b != 8'h0D) begin
                    n_err = 1'b1;
                end
                if (at_last && last_q && n_have) emit = 1'b1;

                if (emit) begin
                    res_d   = '{value: n_acc, overflow: n_ovf, error: n_err};
                    acc_d   = '0;
                    have_d  = 1'b0;
                    ovf_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = EMIT;
                end else begin
                    acc_d  = n_acc;
                    have_d = n_have;
                    ovf_d  = n_ovf;
                    err_d  = n_err;
                    if (at_last) begin
                        state_d = IDLE;
                        // A final word never leaks a partial value into the next stream.
                        if (last_q) begin
                            acc_d  = '0;
                            have_d = 1'b0;
                            ovf_d  = 1'b0;
                            err_d  = 1'b0;
                        end
                    end else begin
                        cursor_d = cursor_q + 1'b1;
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    cnt_d = cnt_q + 16'd1;
                    if (at_last) begin
                        state_d = IDLE;
                    end else begin
                        cursor_d = cursor_q + 1'b1;
                        state_d  = SCAN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            buf_q    <= '0;
            last_q   <= 1'b0;
            cursor_q <= '0;
            acc_q    <= '0;
            have_q   <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            res_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            last_q   <= last_d;
            cursor_q <= cursor_d;
            acc_q    <= acc_d;
            have_q   <= have_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_ready     = (state_q == IDLE) && !rst;
    assign out_valid    = (state_q == EMIT);
    assign out_value    = res_q.value;
    assign out_overflow = res_q.overflow;
    assign out_error    = res_q.error;
    assign line_count   = cnt_q;
endmodule

// File: doc/line_number_parser.md
# line_number_parser

Parametrised successor to the fixed 8-byte newline-index finder in the AOC number-input path. It accepts a stream of packed ASCII words, each LANES bytes wide. It splits the stream on a separator byte and converts each line's decimal digits into an unsigned integer, one result per line. Lines may span word boundaries, a word may hold several lines, and results are delivered through a valid/ready handshake to the downstream puzzle datapath.

## Interface
Parameters:
- LANES, 8: bytes per input word; must be ≥1.
- VALUE_WIDTH, 32: width of the parsed value.
- SEPARATOR, 8'h0A: line-terminator byte.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  8*LANES  packed bytes; lane 0 = bits [7:0] is first in stream order.
- in_last  in  1  word is final; a pending number is flushed after its last lane.
- in_valid  in  1  in_data and in_last are valid.
- in_ready  out  1  block can accept a word.
- out_value  out  VALUE_WIDTH  parsed number.
- out_overflow  out  1  value exceeded 2^VALUE_WIDTH−1 during accumulation.
- out_error  out  1  line contained a byte that is not a digit, SEPARATOR, 8'h00 or 8'h0D.
- out_valid  out  1  result is valid.
- out_ready  in  1  downstream accepts the result.
- line_count  out  16  number of results accepted downstream; wraps at 2^16.

## Operation
- Internal state: word buffer, last flag, lane cursor (clog2(LANES) bits, min 1), accumulator acc[VALUE_WIDTH-1:0], have_digit, ovf and err sticky bits.
- **IDLE**
  - in_ready=1.
  - On in_valid: capture in_data and in_last, set cursor=0, go to SCAN.
- **SCAN**
  - in_ready=0. Process byte b = buffer lane[cursor], one lane per cycle.
  - Digit '0'..'9': acc ← (acc*10 + (b−8'h30)) mod 2^VALUE_WIDTH; ovf |= true result ≥ 2^VALUE_WIDTH (compute at VALUE_WIDTH+4 bits); have_digit ← 1.
  - b == SEPARATOR with have_digit=1: load out_value/out_overflow/out_error from acc/ovf/err; clear acc, have_digit, ovf, err; go to EMIT.
  - b == SEPARATOR with have_digit=0: blank line. Clear err; no output.
  - 8'h00 (padding) and 8'h0D: ignored.
  - Any other byte: err ← 1.
  - Last lane (cursor==LANES−1), not already emitting:
    - last flag=1 and have_digit=1 after this byte: flush to EMIT as above.
    - Otherwise go to IDLE; acc and flags persist into the next word.
    - If last flag=1, acc and all flags are cleared either way.
  - Otherwise cursor+1, remain in SCAN.
- **EMIT**
  - out_valid=1; outputs held stable.
  - On out_ready: line_count+1; return to SCAN with cursor+1, or to IDLE if the cursor was the last lane.
- A SEPARATOR processed while have_digit=0 never emits, so leading and consecutive separators produce nothing.
- Digits before a non-digit byte still count toward the value; err marks the line as suspect.

## Timing
- Reset values: in_ready=0 during the reset cycle, then 1 (IDLE); out_valid=0; out_value=0; out_overflow=0; out_error=0; line_count=0; acc, cursor and flags=0.
- A word accepted at edge T has lane k processed in cycle T+1+k plus the EMIT cycles spent on earlier lanes of the same word.
- out_valid rises the cycle after the separator (or flushed final lane) is processed. The minimum EMIT residency is 1 cycle when out_ready=1.
- Word throughput: LANES + (results in word) cycles, plus 1 IDLE cycle per word. in_ready is high only in IDLE.
- Backpressure: while out_valid=1 and out_ready=0, the cursor does not advance and outputs do not change.
- Reset asserted mid-SCAN or mid-EMIT discards the buffered word, the partial acc and any pending result. No output occurs the cycle after reset.
- line_count increments exactly on out_valid & out_ready.

## Test plan
- LANES=8, word "12\n3456\n" (lane 0='1'): outputs 12 then 3456, err=0, ovf=0, line_count=2; in_ready low for 10 cycles.
- Spanning words: "00001969" then "\n" followed by 7 bytes of 8'h00: a single output 1969 after lane 0 of the second word; leading zeros accepted.
- Blank and padding: "\n\n\r\n" followed by 4×8'h00: no out_valid; in_ready returns after 8 SCAN cycles.
- Backpressure: "7\n8\n" with out_ready held low 5 cycles: out_value=7 stable for 6 cycles, then 8; no lane is skipped.
- Flush with in_last=1 on "100756" + 2×8'h00: emits 100756 at the end of lane 7; then in_ready=1 with acc cleared. A following "5\n" emits 5, not 1007565.
- VALUE_WIDTH=8, "300\n": out_value=44, out_overflow=1. "4x2\n": out_value=42, out_error=1. Reset asserted during EMIT: out_valid=0 next cycle and line_count=0.
